// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide unit: one bit per clock, start/busy/done handshake.
// Signed ops run on magnitudes; the FIX state applies sign correction and loads hi/lo.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, next_state;

    logic                 is_div_r;
    logic                 sa, sb;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     mb;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH+1:0]     alu_x, alu_y, alu_sum;
    logic                 alu_cin;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     q_fix, r_fix;
    logic                 div_zero;

    assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

    // Single shared adder: multiply adds the multiplicand into the upper half,
    // divide subtracts the divisor from the shifted partial remainder (extra bit
    // keeps the borrow unambiguous even for a zero divisor).
    always_comb begin
        alu_x   = '0;
        alu_y   = '0;
        alu_cin = 1'b0;
        if (is_div_r) begin
            alu_x   = {1'b0, acc[2*WIDTH-1:WIDTH-1]};
            alu_y   = ~{2'b00, mb};
            alu_cin = 1'b1;
        end else begin
            alu_x = {2'b00, acc[2*WIDTH-1:WIDTH]};
            alu_y = acc[0] ? {2'b00, mb} : '0;
        end
        alu_sum = alu_x + alu_y + {{(WIDTH+1){1'b0}}, alu_cin};
    end

    always_comb begin
        acc_next = acc;
        if (is_div_r) begin
            if (!alu_sum[WIDTH+1])
                acc_next = {alu_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {alu_sum[WIDTH:0], acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = (sa ^ sb) ? -acc : acc;
        q_fix    = acc[WIDTH-1:0];
        r_fix    = acc[2*WIDTH-1:WIDTH];
        if (sa ^ sb)
            q_fix = -acc[WIDTH-1:0];
        if (sa)
            r_fix = -acc[2*WIDTH-1:WIDTH];
        div_zero = (mb == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            is_div_r <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            a_r      <= '0;
            mb       <= '0;
            acc      <= '0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_r <= op[1];
                        sa       <= op[0] & a[WIDTH-1];
                        sb       <= op[0] & b[WIDTH-1];
                        a_r      <= a;
                        mb       <= abs_b;
                        acc      <= {{WIDTH{1'b0}}, abs_a};
                        count    <= CW'(WIDTH - 1);
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (count != '0)
                        count <= count - CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (is_div_r) begin
                        if (div_zero) begin
                            lo <= '1;
                            hi <= a_r;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
